tcm_lsu_port: RTL and testbench
===============================

TCM_LSU_PORT -- requirements
Module: tcm_lsu_port

Interface
REQ-001 Parameter TCM_WORDS, default 32: number of 32-bit words in the attached TCM port; legal word index is 0..TCM_WORDS-1.
REQ-002 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-low.
REQ-004 req_valid_i  in  1  load/store request present.
REQ-005 req_ready_o  out  1  block can accept a request this cycle.
REQ-006 req_addr_i  in  32  byte address.
REQ-007 req_wdata_i  in  32  store data, right-aligned.
REQ-008 req_we_i  in  1  1 = store, 0 = load.
REQ-009 req_size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
REQ-010 req_signed_i  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-011 req_tag_i  in  4  request ID, returned unchanged.
REQ-012 resp_valid_o  out  1  response present.
REQ-013 resp_ready_i  in  1  consumer accepts the response.
REQ-014 resp_rdata_o  out  32  load result; 0 for stores and errors.
REQ-015 resp_tag_o  out  4  tag of the completed request.
REQ-016 resp_err_o  out  1  request was misaligned, illegal-size or out of range; the TCM is not accessed.
REQ-017 tcm_addr_o  out  14  TCM word index (req_addr_i[15:2]).
REQ-018 tcm_data_o  out  32  TCM write data, lane-replicated.
REQ-019 tcm_wr_o  out  4  TCM byte write strobes.
REQ-020 tcm_data_i  in  32  TCM read data, valid one cycle after the issue cycle (registered, read-first).

Function
REQ-021 States: IDLE, ISSUE, CAPTURE, RESP; exactly one request outstanding.
REQ-022 req_ready_o = 1 only in IDLE; acceptance = req_valid_i & req_ready_o at a rising edge; all request fields are registered at acceptance.
REQ-023 Error check at acceptance: size 3; half with addr[0]=1; word with addr[1:0]!=0; addr[31:16]!=0; addr[15:2]>=TCM_WORDS.
REQ-024 Erroring request: IDLE->RESP; resp_err_o=1, resp_rdata_o=0; tcm_wr_o stays 0; resp_valid_o asserted 1 cycle after acceptance.
REQ-025 Legal request: IDLE->ISSUE; tcm_addr_o, tcm_data_o and tcm_wr_o are registered and driven only during ISSUE (tcm_wr_o=0 in all other states).
REQ-026 Strobes: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111; strobes are 0 for loads.
REQ-027 tcm_data_o: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-028 ISSUE->CAPTURE unconditionally; in CAPTURE tcm_data_i is shifted right by addr[1:0]*8, masked to the access size, and extended per req_signed_i into the response register.
REQ-029 CAPTURE->RESP; legal request has resp_valid_o 3 cycles after acceptance; stores return rdata 0, err 0.
REQ-030 RESP holds resp_* stable until resp_valid_o & resp_ready_i, then RESP->IDLE; the next request can be accepted on the following cycle.
REQ-031 Requests are never dropped or reordered; req_valid_i outside IDLE has no effect.

Reset
REQ-032 rst_i low immediately forces IDLE and clears all outputs to 0: resp_*, tcm_addr_o, tcm_data_o, tcm_wr_o and req_ready_o.
REQ-033 req_ready_o is 0 while rst_i is low and is 1 in the first cycle after rst_i rises.
REQ-034 Reset during ISSUE, CAPTURE or RESP abandons the request with no response; tcm_wr_o drops to 0 asynchronously.

Verification
REQ-035 Word store then load:
- store addr 0x10, wdata 0xDEADBEEF, size 2 -> ISSUE with tcm_addr_o=4, tcm_wr_o=1111.
- load addr 0x10 -> resp_rdata_o 0xDEADBEEF 3 cycles after acceptance, err 0.
REQ-036 Byte store 0xA5 to addr 0x13 -> tcm_wr_o=1000, tcm_data_o=0xA5A5A5A5; signed byte load of 0x13 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-037 Half load at addr 0x12 with word 0x8001xxxx -> signed 0xFFFF8001, unsigned 0x00008001.
REQ-038 Errors, each with resp_err_o=1, rdata 0, one-cycle latency and no tcm_wr_o pulse:
- word at 0x02;
- half at 0x01;
- size 3;
- addr 0x80 with TCM_WORDS=32.
REQ-039 Backpressure: resp_ready_i held 0 for 5 cycles -> resp_* stable and req_ready_o=0 throughout; a tag-7 request accepted one cycle after the response handshake.
REQ-040 Reset asserted during ISSUE of a store -> tcm_wr_o=0 immediately, no response, req_ready_o=1 in the first cycle after release.

Source files
------------

// File: rtl/tcm_lsu_port.sv
// tcm_lsu_port: single-outstanding load/store port onto a registered, read-first word TCM
module tcm_lsu_port #(
    parameter int TCM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [3:0]  req_tag_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic [3:0]  resp_tag_o,
    output logic        resp_err_o,
    output logic [13:0] tcm_addr_o,
    output logic [31:0] tcm_data_o,
    output logic [3:0]  tcm_wr_o,
    input  logic [31:0] tcm_data_i
);
    localparam logic [31:0] WORDS = 32'(TCM_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept, req_err;
    logic [3:0]  strb;
    logic [31:0] wdata_rep, shifted, load_data;
    logic [1:0]  off_q, size_q;
    logic        signed_q, we_q;

    // ready is gated by reset so it reads 0 while reset is held
    assign req_ready_o  = rst_i & (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign accept       = req_valid_i & req_ready_o;

    // classify the incoming request and build its lane strobes and replicated data
    always_comb begin
        req_err   = (req_size_i == 2'd3)
                  | ((req_size_i == 2'd1) & req_addr_i[0])
                  | ((req_size_i == 2'd2) & (req_addr_i[1:0] != 2'd0))
                  | (req_addr_i[31:16] != 16'd0)
                  | ({18'd0, req_addr_i[15:2]} >= WORDS);
        strb      = !req_we_i ? 4'b0000 :
                    req_size_i == 2'd0 ? 4'b0001 << req_addr_i[1:0] :
                    req_size_i == 2'd1 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_rep = req_size_i == 2'd0 ? {4{req_wdata_i[7:0]}} :
                    req_size_i == 2'd1 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    end

    // align the TCM word to the access offset, then mask and extend to the access size
    always_comb begin
        shifted   = tcm_data_i >> {off_q, 3'b000};
        load_data = size_q == 2'd0 ? {{24{signed_q & shifted[7]}}, shifted[7:0]} :
                    size_q == 2'd1 ? {{16{signed_q & shifted[15]}}, shifted[15:0]} : shifted;
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: errors skip the TCM, legal requests issue then capture
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_err ? RESP : ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (resp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // request capture, one-cycle TCM drive during ISSUE, and response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tcm_addr_o   <= '0;
            tcm_data_o   <= '0;
            tcm_wr_o     <= '0;
            resp_rdata_o <= '0;
            resp_tag_o   <= '0;
            resp_err_o   <= 1'b0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            tcm_addr_o <= '0;
            tcm_data_o <= '0;
            tcm_wr_o   <= '0;
            if (accept) begin
                off_q        <= req_addr_i[1:0];
                size_q       <= req_size_i;
                signed_q     <= req_signed_i;
                we_q         <= req_we_i;
                resp_tag_o   <= req_tag_i;
                resp_err_o   <= req_err;
                resp_rdata_o <= '0;
                if (!req_err) begin
                    tcm_addr_o <= req_addr_i[15:2];
                    tcm_data_o <= wdata_rep;
                    tcm_wr_o   <= strb;
                end
            end
            if (state == CAPTURE) resp_rdata_o <= we_q ? '0 : load_data;
        end
    end
endmodule

// File: tb/tb_tcm_lsu_port.sv
// tb_tcm_lsu_port: randomized scoreboard bench with a byte-level memory reference model
module tb_tcm_lsu_port;
    localparam int TW = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = '0;
    logic        req_signed_i = 1'b0;
    logic [3:0]  req_tag_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic [3:0]  resp_tag_o;
    logic        resp_err_o;
    logic [13:0] tcm_addr_o;
    logic [31:0] tcm_data_o;
    logic [3:0]  tcm_wr_o;
    logic [31:0] tcm_data_i = '0;

    tcm_lsu_port #(.TCM_WORDS(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_tag_i(req_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o),
        .tcm_addr_o(tcm_addr_o), .tcm_data_o(tcm_data_o), .tcm_wr_o(tcm_wr_o),
        .tcm_data_i(tcm_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  tag;
        int          acc;
        logic [3:0]  wr;
        logic [13:0] ta;
        logic [31:0] td;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, hs_cyc = 0, bp_cnt = 0, pulses = 0;
    bit          rand_rdy = 0, follow = 0, seen = 0, held = 0;
    logic [31:0] prev_rdata;
    logic [3:0]  prev_tag;
    logic        prev_err;
    logic [31:0] tcm_mem [0:TW-1];
    logic [7:0]  ref_mem [0:4*TW-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // environment TCM: registered, read-first, byte strobed
    always @(posedge clk_i) begin
        tcm_data_i <= tcm_mem[int'(tcm_addr_o) % TW];
        for (int b = 0; b < 4; b++)
            if (tcm_wr_o[b]) tcm_mem[int'(tcm_addr_o) % TW][8*b +: 8] <= tcm_data_o[8*b +: 8];
    end

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic is_err(input logic [31:0] a, input logic [1:0] sz);
        return sz == 2'd3 || (a % nbytes(sz)) != 0 || a >= 32'(4 * TW);
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] w, input logic we,
                        input logic [1:0] sz, input logic sg, input logic [3:0] tg, input logic keep);
        exp_t e;
        int n = 0;
        int nb = nbytes(sz);
        @(negedge clk_i);
        while (!req_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            chk("accept_timeout", 32'(req_ready_o), 1);
            return;
        end
        e.err = is_err(a, sz);
        e.tag = tg;
        e.acc = cyc;
        e.ta = a[15:2];
        e.wr = '0;
        e.td = '0;
        e.rdata = '0;
        if (!e.err && we) begin
            for (int k = 0; k < nb; k++) e.wr[int'(a % 4) + k] = 1'b1;
            for (int l = 0; l < 4; l++) e.td[8*l +: 8] = w[8*(l % nb) +: 8];
        end else if (!e.err) begin
            for (int k = 0; k < nb; k++) e.rdata[8*k +: 8] = ref_mem[int'(a) + k];
            if (sg && nb < 4 && e.rdata[8*nb-1])
                for (int j = 8*nb; j < 32; j++) e.rdata[j] = 1'b1;
        end
        if (follow) chk("follow_accept", 32'(cyc - hs_cyc), 1);
        q.push_back(e);
        req_valid_i = 1'b1;
        req_addr_i = a;
        req_wdata_i = w;
        req_we_i = we;
        req_size_i = sz;
        req_signed_i = sg;
        req_tag_i = tg;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_addr_i = $urandom;
        req_wdata_i = $urandom;
        req_tag_i = 4'($urandom);
        if (keep && we && !e.err)
            for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = w[8*k +: 8];
    endtask

    // response consumer and scoreboard monitor
    always @(negedge clk_i) begin
        if (!rst_i) begin
            seen = 0;
            held = 0;
            pulses = 0;
        end else begin
            if (resp_valid_o && bp_cnt > 0) begin
                resp_ready_i = 1'b0;
                bp_cnt--;
            end else resp_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tcm_wr_o != 4'd0) begin
                pulses++;
                if (q.size() == 0) chk("stray_tcm_wr", 32'(tcm_wr_o), 0);
                else begin
                    chk("tcm_wr", 32'(tcm_wr_o), 32'(q[0].wr));
                    chk("tcm_addr", 32'(tcm_addr_o), 32'(q[0].ta));
                    chk("tcm_data", tcm_data_o, q[0].td);
                end
            end
            if (held) begin
                chk("hold_valid", 32'(resp_valid_o), 1);
                chk("hold_rdata", resp_rdata_o, prev_rdata);
                chk("hold_tag", 32'(resp_tag_o), 32'(prev_tag));
                chk("hold_err", 32'(resp_err_o), 32'(prev_err));
            end
            held = 0;
            if (resp_valid_o) begin
                chk("busy_ready", 32'(req_ready_o), 0);
                if (q.size() == 0) chk("stray_resp", 32'(resp_valid_o), 0);
                else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - q[0].acc), q[0].err ? 32'd1 : 32'd3);
                        seen = 1;
                    end
                    if (resp_ready_i) begin
                        chk("rdata", resp_rdata_o, q[0].rdata);
                        chk("err", 32'(resp_err_o), 32'(q[0].err));
                        chk("tag", 32'(resp_tag_o), 32'(q[0].tag));
                        chk("wr_pulses", 32'(pulses), 32'(q[0].wr != 4'd0));
                        void'(q.pop_front());
                        pulses = 0;
                        seen = 0;
                        hs_cyc = cyc;
                    end else begin
                        held = 1;
                        prev_rdata = resp_rdata_o;
                        prev_tag = resp_tag_o;
                        prev_err = resp_err_o;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [1:0] s;
        for (int i = 0; i < TW; i++) begin
            a = $urandom;
            tcm_mem[i] = a;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = a[8*k +: 8];
        end
        #1 rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        chk("rst_resp_rdata", resp_rdata_o, 0);
        chk("rst_resp_tag", 32'(resp_tag_o), 0);
        chk("rst_resp_err", 32'(resp_err_o), 0);
        chk("rst_tcm_wr", 32'(tcm_wr_o), 0);
        chk("rst_tcm_addr", 32'(tcm_addr_o), 0);
        chk("rst_tcm_data", tcm_data_o, 0);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("ready_after_rst", 32'(req_ready_o), 1);

        send(32'h10, 32'hDEADBEEF, 1, 2'd2, 0, 4'd1, 1);
        send(32'h10, $urandom, 0, 2'd2, 0, 4'd2, 1);
        send(32'h13, 32'h000000A5, 1, 2'd0, 0, 4'd3, 1);
        send(32'h13, $urandom, 0, 2'd0, 1, 4'd4, 1);
        send(32'h13, $urandom, 0, 2'd0, 0, 4'd5, 1);
        send(32'h10, 32'h80011234, 1, 2'd2, 0, 4'd6, 1);
        send(32'h12, $urandom, 0, 2'd1, 1, 4'd8, 1);
        send(32'h12, $urandom, 0, 2'd1, 0, 4'd9, 1);
        send(32'h02, $urandom, 1, 2'd2, 0, 4'd10, 1);
        send(32'h01, $urandom, 1, 2'd1, 0, 4'd11, 1);
        send(32'h04, $urandom, 1, 2'd3, 0, 4'd12, 1);
        send(32'h80, $urandom, 1, 2'd2, 0, 4'd13, 1);

        bp_cnt = 5;
        send(32'h10, $urandom, 0, 2'd2, 0, 4'd3, 1);
        follow = 1;
        send(32'h20, $urandom, 0, 2'd2, 0, 4'd7, 1);
        follow = 0;

        send(32'h18, 32'h12345678, 1, 2'd2, 0, 4'd14, 0);
        chk("issue_wr", 32'(tcm_wr_o), 32'hF);
        rst_i = 1'b0;
        #1;
        chk("rst_issue_wr", 32'(tcm_wr_o), 0);
        chk("rst_issue_ready", 32'(req_ready_o), 0);
        chk("rst_issue_valid", 32'(resp_valid_o), 0);
        q.delete();
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("ready_after_rst2", 32'(req_ready_o), 1);
        repeat (8) @(negedge clk_i);
        chk("no_resp_after_rst", 32'(resp_valid_o), 0);
        send(32'h18, $urandom, 0, 2'd2, 0, 4'd15, 1);

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 9);
            a = n == 0 ? $urandom : n == 1 ? 32'h80 + $urandom_range(0, 63) : $urandom_range(0, 4*TW - 1);
            s = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            send(a, $urandom, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1);
        end

        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (q.size() > 0) chk("drain", 32'(q.size()), 0);
        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
